// File: rtl/trng_pkg.sv
// trng_pkg: definitions shared by the TRNG entropy collector.
//   state_t           - collector state (FILL / FULL / FAIL)
//   FC_RCT / FC_APT   - bit positions inside fail_cause
//   DEF_*             - default block width and health-test cutoffs
//   cnt_width()       - width of a counter that must hold 0..max inclusive
package trng_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    FAIL = 2'd2
  } state_t;

  localparam int FC_RCT = 0;
  localparam int FC_APT = 1;

  localparam int DEF_BLOCK_W    = 512;
  localparam int DEF_RCT_CUTOFF = 32;
  localparam int DEF_APT_CUTOFF = 410;

  function automatic int cnt_width(input int max_value);
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/entropy_collector_if.sv
// entropy_collector_if: block hand-off from the entropy collector to the
// SHA-256 conditioner.
//   data_out    - packed raw block (collector -> conditioner)
//   block_valid - data_out holds a complete, healthy block
//   block_ready - conditioner can take the block
// master = collector side, slave = conditioner side.
interface entropy_collector_if
  import trng_pkg::*;
#(
  parameter int BLOCK_W = DEF_BLOCK_W
);

  logic [BLOCK_W-1:0] data_out;
  logic               block_valid;
  logic               block_ready;

  modport master (output data_out, output block_valid, input block_ready);
  modport slave  (input data_out, input block_valid, output block_ready);

endinterface

// File: rtl/trng_health_test.sv
// trng_health_test: continuous health tests on accepted raw samples.
//   clk, Resetn  - clock, asynchronous active-low reset
//   sample       - current raw bit
//   sample_en    - sample is accepted this cycle
//   block_start  - sample is the first of a new block (opens the APT window)
//   clear        - drop run and proportion counts (failure acknowledged)
//   rct_fail     - repetition count test trips on the current sample
//   apt_fail     - adaptive proportion test trips on the current sample
// Both fail outputs are combinational so the collector can react on the
// same edge that would otherwise store the sample.
module trng_health_test
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
  input  logic clk,
  input  logic Resetn,
  input  logic sample,
  input  logic sample_en,
  input  logic block_start,
  input  logic clear,
  output logic rct_fail,
  output logic apt_fail
);

  localparam int RW = cnt_width(RCT_CUTOFF);
  localparam int AW = cnt_width(APT_CUTOFF);

  logic          last_bit;
  logic [RW-1:0] run_cnt;
  logic [RW-1:0] run_next;
  logic          apt_ref;
  logic [AW-1:0] apt_cnt;
  logic [AW-1:0] apt_next;

  // run_cnt==0 means no sample seen since reset/clear, so the next sample
  // always starts a fresh run. Both counters saturate at their cutoff.
  always_comb begin
    run_next = RW'(1);
    if (run_cnt != '0 && sample == last_bit) begin
      run_next = (run_cnt == RW'(RCT_CUTOFF)) ? run_cnt : run_cnt + 1'b1;
    end

    apt_next = apt_cnt;
    if (block_start) begin
      apt_next = AW'(1);
    end else if (sample == apt_ref && apt_cnt != AW'(APT_CUTOFF)) begin
      apt_next = apt_cnt + 1'b1;
    end
  end

  assign rct_fail = sample_en && (run_next == RW'(RCT_CUTOFF));
  assign apt_fail = sample_en && (apt_next == AW'(APT_CUTOFF));

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      last_bit <= 1'b0;
      run_cnt  <= '0;
      apt_ref  <= 1'b0;
      apt_cnt  <= '0;
    end else if (clear) begin
      run_cnt <= '0;
      apt_cnt <= '0;
    end else if (sample_en) begin
      last_bit <= sample;
      run_cnt  <= run_next;
      apt_cnt  <= apt_next;
      if (block_start) begin
        apt_ref <= sample;
      end
    end
  end

endmodule

// File: rtl/entropy_collector.sv
// entropy_collector: packs health-tested raw entropy bits into blocks for
// the SHA-256 conditioner.
//   clk, Resetn  - clock, asynchronous active-low reset
//   enable       - when low, samples are ignored
//   raw_bit      - raw entropy sample, qualified by raw_valid
//   fail_clear   - one-cycle pulse that leaves the failure state
//   blk          - block hand-off (data_out / block_valid / block_ready)
//   health_fail  - sticky health-test failure flag
//   fail_cause   - which test tripped (FC_RCT, FC_APT)
module entropy_collector
  import trng_pkg::*;
#(
  parameter int BLOCK_W    = DEF_BLOCK_W,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
  input  logic                clk,
  input  logic                Resetn,
  input  logic                enable,
  input  logic                raw_bit,
  input  logic                raw_valid,
  input  logic                fail_clear,
  entropy_collector_if.master blk,
  output logic                health_fail,
  output logic [1:0]          fail_cause
);

  localparam int CW = $clog2(BLOCK_W) + 1;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] bit_cnt;
  logic          accept;
  logic          last_sample;
  logic          block_start;
  logic          handoff;
  logic          health_clear;
  logic          rct_fail;
  logic          apt_fail;

  assign accept       = raw_valid && enable && (state == FILL);
  assign last_sample  = (bit_cnt == CW'(BLOCK_W - 1));
  assign block_start  = (bit_cnt == '0);
  assign handoff      = (state == FULL) && blk.block_ready;
  assign health_clear = (state == FAIL) && fail_clear;

  // Status outputs come straight from the state register, so block_valid
  // never follows block_ready combinationally.
  assign blk.block_valid = (state == FULL);
  assign health_fail     = (state == FAIL);

  trng_health_test #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_health (
    .clk         (clk),
    .Resetn      (Resetn),
    .sample      (raw_bit),
    .sample_en   (accept),
    .block_start (block_start),
    .clear       (health_clear),
    .rct_fail    (rct_fail),
    .apt_fail    (apt_fail)
  );

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // A trip on the final sample of a block takes priority, so an unhealthy
  // block is never presented.
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (accept && (rct_fail || apt_fail)) begin
          state_next = FAIL;
        end else if (accept && last_sample) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (blk.block_ready) begin
          state_next = FILL;
        end
      end
      FAIL: begin
        if (fail_clear) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Shift register, bit counter and failure cause. data_out is left alone
  // on clear; the restarted bit counter means the next block overwrites it.
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      blk.data_out <= '0;
      bit_cnt      <= '0;
      fail_cause   <= '0;
    end else if (accept) begin
      blk.data_out <= {blk.data_out[BLOCK_W-2:0], raw_bit};
      bit_cnt      <= bit_cnt + 1'b1;
      if (rct_fail || apt_fail) begin
        fail_cause[FC_RCT] <= rct_fail;
        fail_cause[FC_APT] <= apt_fail;
      end
    end else if (handoff) begin
      bit_cnt <= '0;
    end else if (health_clear) begin
      bit_cnt    <= '0;
      fail_cause <= '0;
    end
  end

endmodule

// File: tb/tb_entropy_collector.sv
// tb_entropy_collector: directed self-checking bench for entropy_collector.
// Inputs change on the falling edge; outputs are checked on the falling
// edge after the rising edge that consumed them.
module tb_entropy_collector;

  localparam int BW = 512;

  logic       clk = 1'b0;
  logic       Resetn;
  logic       enable;
  logic       raw_bit;
  logic       raw_valid;
  logic       fail_clear;
  logic       health_fail;
  logic [1:0] fail_cause;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] alt10;
  logic [BW-1:0] alt01;

  entropy_collector_if #(.BLOCK_W(BW)) blk ();

  entropy_collector dut (
    .clk         (clk),
    .Resetn      (Resetn),
    .enable      (enable),
    .raw_bit     (raw_bit),
    .raw_valid   (raw_valid),
    .fail_clear  (fail_clear),
    .blk         (blk),
    .health_fail (health_fail),
    .fail_cause  (fail_cause)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [BW-1:0] observed,
                              input logic [BW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of sample inputs and return on the next falling edge.
  task automatic apply_stimulus(input logic b, input logic v);
    raw_bit   = b;
    raw_valid = v;
    @(negedge clk);
  endtask

  // n accepted-looking samples alternating, starting with first.
  task automatic feed_alt(input int n, input logic first);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(first ^ i[0], 1'b1);
    end
  endtask

  task automatic pulse_reset();
    Resetn = 1'b0;
    @(negedge clk);
    Resetn = 1'b1;
  endtask

  initial begin
    Resetn = 1'b0;
    enable = 1'b1;
    raw_bit = 1'b0;
    raw_valid = 1'b0;
    fail_clear = 1'b0;
    blk.block_ready = 1'b0;
    alt10 = {256{2'b10}};
    alt01 = {256{2'b01}};
    repeat (2) @(negedge clk);

    check_output("rst_data", blk.data_out, '0);
    check_output("rst_valid", BW'(blk.block_valid), BW'(0));
    check_output("rst_hfail", BW'(health_fail), BW'(0));
    check_output("rst_cause", BW'(fail_cause), BW'(0));
    Resetn = 1'b1;
    @(negedge clk);

    // Scenario 1: alternating block with the conditioner always ready.
    blk.block_ready = 1'b1;
    feed_alt(511, 1'b1);
    check_output("s1_not_early", BW'(blk.block_valid), BW'(0));
    apply_stimulus(1'b0, 1'b1);
    check_output("s1_valid", BW'(blk.block_valid), BW'(1));
    check_output("s1_data", blk.data_out, alt10);
    check_output("s1_hfail", BW'(health_fail), BW'(0));
    apply_stimulus(1'b1, 1'b1);
    check_output("s1_one_cycle", BW'(blk.block_valid), BW'(0));

    // Scenario 4: next block (transfer-cycle sample must have been dropped),
    // then back-pressure while samples keep arriving.
    blk.block_ready = 1'b0;
    feed_alt(511, 1'b0);
    check_output("s4_not_early", BW'(blk.block_valid), BW'(0));
    apply_stimulus(1'b1, 1'b1);
    check_output("s4_valid", BW'(blk.block_valid), BW'(1));
    check_output("s4_data", blk.data_out, alt01);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b1);
    end
    check_output("s4_held_data", blk.data_out, alt01);
    check_output("s4_held_valid", BW'(blk.block_valid), BW'(1));
    enable = 1'b0;
    blk.block_ready = 1'b1;
    apply_stimulus(1'b1, 1'b1);
    check_output("s4_xfer_en_low", BW'(blk.block_valid), BW'(0));
    blk.block_ready = 1'b0;
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    enable = 1'b1;
    feed_alt(200, 1'b1);
    enable = 1'b0;
    repeat (5) apply_stimulus(1'b0, 1'b1);
    enable = 1'b1;
    feed_alt(311, 1'b1);
    check_output("s4_resume_not_early", BW'(blk.block_valid), BW'(0));
    apply_stimulus(1'b0, 1'b1);
    check_output("s4_resume_valid", BW'(blk.block_valid), BW'(1));
    check_output("s4_resume_data", blk.data_out, alt10);
    blk.block_ready = 1'b1;
    apply_stimulus(1'b0, 1'b0);
    check_output("s4_resume_xfer", BW'(blk.block_valid), BW'(0));

    // Scenario 5: asynchronous reset part-way through a block.
    feed_alt(300, 1'b1);
    Resetn = 1'b0;
    #1;
    check_output("s5_rst_data", blk.data_out, '0);
    check_output("s5_rst_valid", BW'(blk.block_valid), BW'(0));
    check_output("s5_rst_hfail", BW'(health_fail), BW'(0));
    check_output("s5_rst_cause", BW'(fail_cause), BW'(0));
    @(negedge clk);
    Resetn = 1'b1;
    feed_alt(256, 1'b1);
    fail_clear = 1'b1;
    apply_stimulus(1'b1, 1'b1);
    fail_clear = 1'b0;
    feed_alt(254, 1'b0);
    check_output("s5_not_early", BW'(blk.block_valid), BW'(0));
    apply_stimulus(1'b0, 1'b1);
    check_output("s5_valid", BW'(blk.block_valid), BW'(1));
    check_output("s5_data", blk.data_out, alt10);
    apply_stimulus(1'b0, 1'b0);

    // Scenario 2: 32 ones trip the repetition count test.
    pulse_reset();
    repeat (31) apply_stimulus(1'b1, 1'b1);
    check_output("s2_before_trip", BW'(health_fail), BW'(0));
    apply_stimulus(1'b1, 1'b1);
    check_output("s2_hfail", BW'(health_fail), BW'(1));
    check_output("s2_cause", BW'(fail_cause), BW'(2'b01));
    check_output("s2_no_valid", BW'(blk.block_valid), BW'(0));

    // Scenario 6: samples ignored in FAIL, clear, then a clean block.
    repeat (3) apply_stimulus(1'b1, 1'b1);
    check_output("s6_sticky", BW'(health_fail), BW'(1));
    fail_clear = 1'b1;
    apply_stimulus(1'b1, 1'b1);
    fail_clear = 1'b0;
    check_output("s6_hfail_clr", BW'(health_fail), BW'(0));
    check_output("s6_cause_clr", BW'(fail_cause), BW'(0));
    feed_alt(511, 1'b1);
    check_output("s6_not_early", BW'(blk.block_valid), BW'(0));
    apply_stimulus(1'b0, 1'b1);
    check_output("s6_valid", BW'(blk.block_valid), BW'(1));
    check_output("s6_data", blk.data_out, alt10);
    check_output("s6_hfail", BW'(health_fail), BW'(0));
    apply_stimulus(1'b0, 1'b0);

    // Scenario 3: 31 zeros + 1 one repeated; APT trips on sample 423.
    pulse_reset();
    for (int g = 0; g < 13; g++) begin
      repeat (31) apply_stimulus(1'b0, 1'b1);
      apply_stimulus(1'b1, 1'b1);
    end
    repeat (6) apply_stimulus(1'b0, 1'b1);
    check_output("s3_before_trip", BW'(health_fail), BW'(0));
    apply_stimulus(1'b0, 1'b1);
    check_output("s3_hfail", BW'(health_fail), BW'(1));
    check_output("s3_cause", BW'(fail_cause), BW'(2'b10));
    fail_clear = 1'b1;
    apply_stimulus(1'b0, 1'b0);
    fail_clear = 1'b0;

    // Both tests trip on the same sample: the 410th one ends a run of 32.
    for (int g = 0; g < 12; g++) begin
      repeat (31) apply_stimulus(1'b1, 1'b1);
      apply_stimulus(1'b0, 1'b1);
    end
    repeat (6) apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    repeat (31) apply_stimulus(1'b1, 1'b1);
    check_output("s3b_before_trip", BW'(health_fail), BW'(0));
    apply_stimulus(1'b1, 1'b1);
    check_output("s3b_hfail", BW'(health_fail), BW'(1));
    check_output("s3b_cause", BW'(fail_cause), BW'(2'b11));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
